// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode encoding and parameter helpers for the PWM array
package pwm_pkg;
  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler, shared up/down counter and shadowed top/mode
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int RES   = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_run,
  input  logic             cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [RES-1:0]   cfg_top,
  input  logic             cfg_update,
  output logic [RES-1:0]   cnt,
  output logic             load,
  output logic             start
);
  localparam int PW = 2**DIV_W - 1;
  logic [PW-1:0] pre, lim;
  logic [RES-1:0] top_a, cnt_nx;
  pwm_mode_e mode_a;
  logic tick, up, up_nx, rise, pending, boundary;
  assign lim = ~({PW{1'b1}} << cfg_div);
  assign tick = cfg_run && pre == lim;
  // next counter value and direction; a wrap to zero marks the period boundary
  always_comb begin
    rise = up && cnt < top_a;
    cnt_nx = (mode_a == PWM_EDGE) ? ((cnt >= top_a) ? '0 : cnt + 1'b1) :
             (top_a == '0) ? '0 : rise ? cnt + 1'b1 : cnt - 1'b1;
    up_nx = mode_a == PWM_EDGE || cnt_nx == '0 || rise;
    boundary = tick && cnt_nx == '0;
    load = !cfg_run || (boundary && (pending || cfg_update));
  end
  // timebase state; shadows follow cfg while stopped and at requested boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
      up <= 1'b1;
      pending <= 1'b0;
      start <= 1'b0;
      top_a <= '0;
      mode_a <= PWM_EDGE;
    end else begin
      pre <= (!cfg_run || tick) ? '0 : pre + 1'b1;
      pending <= cfg_run && !load && (pending || cfg_update);
      start <= boundary;
      if (!cfg_run) begin
        cnt <= '0;
        up <= 1'b1;
      end else if (tick) begin
        cnt <= cnt_nx;
        up <= up_nx;
      end
      if (load) begin
        top_a <= cfg_top;
        mode_a <= pwm_mode_e'(cfg_mode);
      end
    end
  end
endmodule

// File: rtl/pwm_gen_array.sv
// pwm_gen_array: shared-timebase PWM generators routed to registered output pins
module pwm_gen_array
  import pwm_pkg::*;
#(
  parameter int NUM_GEN = 4,
  parameter int NUM_OUT = 8,
  parameter int RES     = 8,
  parameter int DIV_W   = 4,
  localparam int SEL_W  = sel_w(NUM_GEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_run,
  input  logic                     cfg_mode,
  input  logic [DIV_W-1:0]         cfg_div,
  input  logic [RES-1:0]           cfg_top,
  input  logic [NUM_GEN*RES-1:0]   cfg_duty,
  input  logic                     cfg_update,
  input  logic [NUM_OUT-1:0]       cfg_en_out,
  input  logic [NUM_OUT-1:0]       cfg_en_pwm,
  input  logic [NUM_OUT*SEL_W-1:0] cfg_sel,
  input  logic [NUM_OUT-1:0]       cfg_pol,
  output logic [NUM_OUT-1:0]       out,
  output logic                     period_start
);
  logic [RES-1:0] cnt;
  logic load, start;
  logic [NUM_GEN-1:0][RES-1:0] duty_a;
  logic [2**SEL_W-1:0] raw;
  logic [NUM_OUT-1:0] pin;
  pwm_timebase #(.RES(RES), .DIV_W(DIV_W)) u_tb (
    .clk(clk), .rst_n(rst_n), .cfg_run(cfg_run), .cfg_mode(cfg_mode),
    .cfg_div(cfg_div), .cfg_top(cfg_top), .cfg_update(cfg_update),
    .cnt(cnt), .load(load), .start(start)
  );
  // duty shadows load together with top/mode so a period never mixes settings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_a <= '0;
    else if (load) duty_a <= cfg_duty;
  end
  // generator compares and per-pin routing; unused selects read as low
  always_comb begin
    raw = '0;
    pin = '0;
    for (int g = 0; g < NUM_GEN; g++) raw[g] = cnt < duty_a[g];
    for (int i = 0; i < NUM_OUT; i++)
      pin[i] = (cfg_en_out[i] && cfg_en_pwm[i]) ?
               (int'(cfg_sel[i*SEL_W +: SEL_W]) < NUM_GEN && (raw[cfg_sel[i*SEL_W +: SEL_W]] ^ cfg_pol[i])) :
               cfg_en_out[i];
  end
  // pins and period strobe are registered so they leave together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      period_start <= 1'b0;
    end else begin
      out <= pin;
      period_start <= start && cfg_run;
    end
  end
endmodule
